// File: rtl/axi_wb_pkg.sv
// Shared encodings for the AXI write-burst beat generator and its command queue.
package axi_wb_pkg;

   localparam logic [1:0] FIXED = 2'b00;
   localparam logic [1:0] INCR  = 2'b01;
   localparam logic [1:0] WRAP  = 2'b10;
   localparam logic [1:0] RSVD  = 2'b11;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BURST = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;

   typedef struct packed {
      logic [7:0] len;
      logic [2:0] size;
      logic [1:0] burst;
   } cmd_meta_t;

   localparam int CMD_META_W = $bits(cmd_meta_t);

endpackage

// File: rtl/axi_cmd_fifo.sv
// Synchronous FIFO holding accepted AW commands. A push into a full queue
// is taken only when a pop retires the head entry in the same cycle.
module axi_cmd_fifo #(
   parameter int WIDTH = 45,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW:0]      wr_ptr_r;
   logic [PW:0]      rd_ptr_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]) && (wr_ptr_r[PW] != rd_ptr_r[PW]);
   assign do_pop_s  = pop && !empty;
   assign do_push_s = push && (!full || do_pop_s);
   assign dout      = mem_r[rd_ptr_r[PW-1:0]];

   // Entry storage and read/write pointer update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {(PW+1){1'b0}};
         rd_ptr_r <= {(PW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r[PW-1:0]] <= din;
            wr_ptr_r                <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/axi_wburst_beat_gen.sv
// Expands queued AXI write bursts into per-beat memory writes and returns a
// checked write response for each burst.
module axi_wburst_beat_gen
   import axi_wb_pkg::*;
#(
   parameter int AW        = 32,
   parameter int DW        = 64,
   parameter int CMD_DEPTH = 2
) (
   input  logic            axi_aclk,
   input  logic            rst_n,
   input  logic [AW-1:0]   axi_awaddr,
   input  logic [7:0]      axi_awlen,
   input  logic [2:0]      axi_awsize,
   input  logic [1:0]      axi_awburst,
   input  logic            axi_awvalid,
   input  logic            axi_awready,
   input  logic [DW-1:0]   axi_wdata,
   input  logic [DW/8-1:0] axi_wstrb,
   input  logic            axi_wlast,
   input  logic            axi_wvalid,
   input  logic            axi_wready,
   input  logic            axi_bready,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_wstrb,
   output logic            bvalid_out,
   output logic [1:0]      bresp_out,
   output logic            cmd_overflow,
   output logic            orphan_beat
);
   localparam int CMD_W = AW + CMD_META_W;

   function automatic logic cmd_check(input logic [11:0] addr_lo, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
      logic [16:0] span;
      logic [16:0] end_off;
      logic        bad_wrap;
      logic        crosses_4k;
      span       = ({9'd0, len} + 17'd1) << size;
      end_off    = {5'd0, addr_lo} + span;
      bad_wrap   = (burst == WRAP) &&
                   !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
      crosses_4k = (burst == INCR) && (end_off > 17'h01000);
      return (size > 3'd3) || (burst == RSVD) || bad_wrap || crosses_4k;
   endfunction

   // The modulo keeps WRAP defined even for illegal lengths whose bound is not a power of two.
   function automatic logic [AW-1:0] step_addr(input logic [AW-1:0] cur, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst);
      logic [AW-1:0] inc;
      logic [AW-1:0] bound;
      logic [AW-1:0] base;
      logic [AW-1:0] result;
      inc   = AW'(1'b1) << size;
      bound = AW'({9'd0, len} + 17'd1) << size;
      base  = cur & ~(bound - AW'(1'b1));
      case (burst)
         FIXED:   result = cur;
         WRAP:    result = base + ((cur + inc - base) % bound);
         default: result = cur + inc;
      endcase
      return result;
   endfunction

   logic [1:0]      state_r;
   logic [AW-1:0]   cur_addr_r;
   logic [7:0]      beats_left_r;
   logic [7:0]      len_r;
   logic [2:0]      size_r;
   logic [1:0]      burst_r;
   logic            err_r;
   logic            no_write_r;
   logic            mem_we_r;
   logic [AW-1:0]   mem_addr_r;
   logic [DW-1:0]   mem_wdata_r;
   logic [DW/8-1:0] mem_wstrb_r;
   logic            bvalid_r;
   logic [1:0]      bresp_r;
   logic            overflow_r;
   logic            orphan_r;

   logic [CMD_W-1:0] q_dout_s;
   logic [AW-1:0]    q_addr_s;
   cmd_meta_t        q_meta_s;
   logic             q_full_s;
   logic             q_empty_s;
   logic             aw_hs_s;
   logic             pop_s;
   logic             push_s;
   logic             drop_s;
   logic             beat_s;
   logic             stray_s;
   logic             final_beat_s;
   logic             wlast_err_s;
   logic             cmd_err_s;
   logic [AW-1:0]    next_addr_s;

   assign aw_hs_s      = axi_awvalid && axi_awready;
   assign pop_s        = (state_r == IDLE) && !q_empty_s;
   assign push_s       = aw_hs_s && (!q_full_s || pop_s);
   assign drop_s       = aw_hs_s && q_full_s && !pop_s;
   assign beat_s       = axi_wvalid && axi_wready && (state_r == BURST);
   assign stray_s      = axi_wvalid && axi_wready && (state_r != BURST);
   assign final_beat_s = beat_s && (beats_left_r == 8'd0);
   assign wlast_err_s  = beat_s && (axi_wlast != (beats_left_r == 8'd0));
   assign {q_addr_s, q_meta_s} = q_dout_s;
   assign cmd_err_s    = cmd_check(q_addr_s[11:0], q_meta_s.len, q_meta_s.size, q_meta_s.burst);
   assign next_addr_s  = step_addr(cur_addr_r, len_r, size_r, burst_r);

   axi_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk   (axi_aclk),
      .rst_n (rst_n),
      .push  (push_s),
      .din   ({axi_awaddr, axi_awlen, axi_awsize, axi_awburst}),
      .pop   (pop_s),
      .dout  (q_dout_s),
      .full  (q_full_s),
      .empty (q_empty_s)
   );

   // Burst sequencing: command load, beat counting and address stepping.
   always_ff @(posedge axi_aclk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         cur_addr_r   <= {AW{1'b0}};
         beats_left_r <= 8'd0;
         len_r        <= 8'd0;
         size_r       <= 3'd0;
         burst_r      <= 2'b00;
         err_r        <= 1'b0;
         no_write_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (pop_s) begin
                  state_r      <= BURST;
                  cur_addr_r   <= q_addr_s;
                  beats_left_r <= q_meta_s.len;
                  len_r        <= q_meta_s.len;
                  size_r       <= q_meta_s.size;
                  burst_r      <= q_meta_s.burst;
                  err_r        <= cmd_err_s;
                  no_write_r   <= (q_meta_s.size > 3'd3);
               end
            end
            BURST: begin
               if (beat_s) begin
                  if (wlast_err_s) begin
                     err_r <= 1'b1;
                  end
                  if (final_beat_s) begin
                     state_r <= RESP;
                  end else begin
                     beats_left_r <= beats_left_r - 8'd1;
                     cur_addr_r   <= next_addr_s;
                  end
               end
            end
            RESP: begin
               if (axi_bready) begin
                  state_r <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // Memory write port, one cycle behind the accepted beat.
   always_ff @(posedge axi_aclk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {AW{1'b0}};
         mem_wdata_r <= {DW{1'b0}};
         mem_wstrb_r <= {(DW/8){1'b0}};
      end else begin
         mem_we_r <= beat_s && !no_write_r;
         if (beat_s && !no_write_r) begin
            mem_addr_r  <= cur_addr_r;
            mem_wdata_r <= axi_wdata;
            mem_wstrb_r <= axi_wstrb;
         end
      end
   end

   // Write response, raised with the final beat and held until bready.
   always_ff @(posedge axi_aclk or negedge rst_n) begin
      if (!rst_n) begin
         bvalid_r <= 1'b0;
         bresp_r  <= OKAY;
      end else if (final_beat_s) begin
         bvalid_r <= 1'b1;
         bresp_r  <= (err_r || wlast_err_s) ? SLVERR : OKAY;
      end else if ((state_r == RESP) && axi_bready) begin
         bvalid_r <= 1'b0;
         bresp_r  <= OKAY;
      end
   end

   // Sticky protocol-error flags.
   always_ff @(posedge axi_aclk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_r <= 1'b0;
         orphan_r   <= 1'b0;
      end else begin
         overflow_r <= overflow_r || drop_s;
         orphan_r   <= orphan_r || stray_s;
      end
   end

   assign mem_we       = mem_we_r;
   assign mem_addr     = mem_addr_r;
   assign mem_wdata    = mem_wdata_r;
   assign mem_wstrb    = mem_wstrb_r;
   assign bvalid_out   = bvalid_r;
   assign bresp_out    = bresp_r;
   assign cmd_overflow = overflow_r;
   assign orphan_beat  = orphan_r;

endmodule

// File: doc/axi_wburst_beat_gen.md
Name: axi_wburst_beat_gen

Overview:
Downstream consumer of the AXI protocol FSM's write-side outputs (AW, W and B channel signals). It captures accepted write-address commands into a small queue and expands each burst into per-beat byte addresses (FIXED/INCR/WRAP). It drives a simple memory write port and produces the write response with error checking. It sits between the protocol FSM and the memory or register model used in verification.

Parameters:
AW, 32, address width
DW, 64, data width in bits; must be 64 to match the W channel
CMD_DEPTH, 2, AW command queue depth; power of two, at least 2

Ports:
axi_aclk  in  1  clock
rst_n  in  1  asynchronous active-low reset
axi_awaddr  in  AW  command start address
axi_awlen  in  8  beats minus 1
axi_awsize  in  3  log2 bytes per beat
axi_awburst  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved
axi_awvalid  in  1  AW valid
axi_awready  in  1  AW ready
axi_wdata  in  DW  beat data
axi_wstrb  in  DW/8  beat byte strobes
axi_wlast  in  1  last-beat marker
axi_wvalid  in  1  W valid
axi_wready  in  1  W ready
axi_bready  in  1  response accept
mem_we  out  1  memory write pulse
mem_addr  out  AW  byte address of the written beat
mem_wdata  out  DW  data of the written beat
mem_wstrb  out  DW/8  strobes of the written beat
bvalid_out  out  1  response valid
bresp_out  out  2  00 OKAY, 10 SLVERR
cmd_overflow  out  1  sticky: a command was dropped because the queue was full
orphan_beat  out  1  sticky: a W beat arrived with no burst active

Behaviour:
- Reset (async assert, sync deassert via rst_n): all outputs 0; queue empty; FSM in IDLE; sticky flags cleared. A reset during a burst abandons the burst; there is no response for it.
- AW capture: when axi_awvalid && axi_awready, push {addr, len, size, burst} into the queue.
  - If the queue is full, drop the command and set cmd_overflow.
  - A push and a pop in the same cycle are both allowed when the queue is full.
- FSM states: IDLE, BURST, RESP.
- IDLE: if the queue is non-empty, pop it, load cur_addr, beats_left = len, size, burst, and err = check(cmd); next state is BURST. The pop takes 1 cycle, so the first beat is accepted at the earliest in the cycle after the pop.
- check(cmd) sets SLVERR if any of:
  - size > 3;
  - burst == 11;
  - WRAP with len not in {1, 3, 7, 15};
  - INCR where (addr & 0xFFF) + ((len+1) << size) > 0x1000 (4 KB crossing).
- BURST: a beat is a cycle with axi_wvalid && axi_wready.
  - On a beat, the next cycle shows mem_we = 1 with mem_addr = cur_addr and the beat's data and strobes (1-cycle latency). mem_we is suppressed for the whole burst when size > 3; for all other errors the writes are still performed.
  - Address step, where inc = 1 << size:
    - FIXED: unchanged.
    - INCR and reserved: cur_addr + inc, modulo 2^AW.
    - WRAP: with bound = (len+1) << size and base = cur_addr & ~(bound-1), the next address is base + ((cur_addr + inc - base) mod bound).
  - wlast check: wlast on a beat with beats_left != 0, or a missing wlast on the beat with beats_left == 0, sets err. The burst always ends on the beat where beats_left == 0; wlast does not end it.
  - After that final beat the FSM moves to RESP; beats_left decrements on every other beat.
- RESP: bvalid_out = 1 and bresp_out = err ? 10 : 00, held stable until axi_bready. On the cycle after the bready handshake, bvalid_out = 0 and the FSM returns to IDLE. The next command may pop on that same IDLE cycle.
- A W beat seen in IDLE or RESP is ignored (no mem_we) and sets orphan_beat.
- Simultaneous AW push and burst completion: the new command is queued normally. Queue order is strictly FIFO.

Decomposition:
- Shared package axi_wb_pkg:
  - burst-type localparams FIXED, INCR, WRAP;
  - response codes OKAY, SLVERR;
  - FSM state encodings IDLE, BURST, RESP;
  - command struct or field widths.
- One sub-module: axi_cmd_fifo, a parameterized synchronous FIFO with async active-low reset and full/empty outputs, holding AW commands.
- Address-step logic and the error checker stay in the top level as combinational functions.

Test Plan:
- INCR, addr 0x100, len 3, size 3, 4 beats with wlast on beat 4 -> mem_addr 0x100, 0x108, 0x110, 0x118; bresp_out 00 once bready.
- WRAP, addr 0x38, len 3, size 2 -> mem_addr 0x38, 0x3C, 0x30, 0x34; bresp_out 00.
- FIXED, addr 0x40, len 2, size 3 -> three writes, all to 0x40. INCR, addr 0xFF8, len 1, size 3 -> writes to 0xFF8 and 0x1000, bresp_out 10.
- Error cases:
  - size 4 -> no mem_we, bresp_out 10.
  - wlast on beat 2 of a len-3 burst -> 4 writes, bresp_out 10.
  - WRAP with len 2 -> bresp_out 10.
- Three back-to-back AW handshakes during one burst with CMD_DEPTH 2 -> third command dropped, cmd_overflow = 1; the two queued bursts complete in order. A W beat in IDLE -> orphan_beat = 1, no mem_we.
- rst_n pulled low mid-burst between beats 2 and 3 -> outputs are 0 immediately (async); after release the queue is empty, and a fresh INCR burst completes with bresp_out 00.
